// File: rtl/fitness_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fitness_eval_pkg
//  Brief    : Shared types, sizes and memory-map constants for the fitness
//             evaluation sequencer.
//  Revision : 1.0
// ============================================================================
package fitness_eval_pkg;

    localparam int ADDR_W      = 15;
    localparam int MAX_SAMPLES = 16384;
    localparam int EXP_OFS     = 0;
    localparam int MASK_OFS    = 1;
    localparam int STRIDE      = 2;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_A     = 4'd1,
        S_RD_B     = 4'd2,
        S_WAIT_MEM = 4'd3,
        S_ISSUE    = 4'd4,
        S_WAIT_OUT = 4'd5,
        S_ACCUM    = 4'd6,
        S_DONE     = 4'd7,
        S_ACK      = 4'd8
    } state_t;

    // Correct-output RAM holds interleaved {expected, mask} pairs per sample.
    function automatic logic [ADDR_W-1:0] corr_addr(input logic [ADDR_W-1:0] idx,
                                                    input logic [ADDR_W-1:0] ofs);
        return idx * ADDR_W'(STRIDE) + ofs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fitness_eval_sequencer_error_accum.sv
`default_nettype none
// ============================================================================
//  Module   : error_accum
//  Brief    : NUM_OUT saturating 32-bit mismatch counters with clear/enable.
//  Revision : 1.0
// ============================================================================
module error_accum #(
    parameter int NUM_OUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic [NUM_OUT-1:0]       mismatch,
    output logic [NUM_OUT-1:0][31:0] sums
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sums <= '0;
        end else if (clear) begin
            sums <= '0;
        end else if (en) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (mismatch[k] && (sums[k] != 32'hFFFF_FFFF)) begin
                    sums[k] <= sums[k] + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fitness_eval_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fitness_eval_sequencer
//  Brief    : Streams N samples and expected/mask words through the evolved
//             circuit evaluator and accumulates per-bit error sums.
//  Revision : 1.0
// ============================================================================
module fitness_eval_sequencer
    import fitness_eval_pkg::*;
#(
    parameter int MEM_RD_LATENCY = 1,
    parameter int NUM_OUT        = 8,
    parameter int EVAL_TIMEOUT   = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start_processing_chrom,
    input  logic [31:0] sequences_to_process,
    input  logic        done_processing_feedback,
    output logic        ready_to_process,
    output logic        done_processing_chrom,
    output logic        eval_timeout,
    output logic [14:0] mem_s2_address,
    output logic        mem_s2_chipselect,
    output logic        mem_s2_clken,
    output logic        mem_s2_write,
    output logic [3:0]  mem_s2_byteenable,
    output logic [31:0] mem_s2_writedata,
    input  logic [31:0] mem_s2_readdata,
    output logic [14:0] correct_mem_s2_address,
    output logic        correct_mem_s2_chipselect,
    output logic        correct_mem_s2_clken,
    output logic        correct_mem_s2_write,
    output logic [3:0]  correct_mem_s2_byteenable,
    output logic [31:0] correct_mem_s2_writedata,
    input  logic [31:0] correct_mem_s2_readdata,
    output logic [31:0] eval_in_data,
    output logic        eval_in_valid,
    input  logic [31:0] eval_out_data,
    input  logic        eval_out_valid,
    output logic [31:0] error_sum_0,
    output logic [31:0] error_sum_1,
    output logic [31:0] error_sum_2,
    output logic [31:0] error_sum_3,
    output logic [31:0] error_sum_4,
    output logic [31:0] error_sum_5,
    output logic [31:0] error_sum_6,
    output logic [31:0] error_sum_7
);

    localparam int TMO_W = $clog2(EVAL_TIMEOUT + 1);

    state_t                  r_state;
    logic                    r_start_q;
    logic [ADDR_W-1:0]       r_idx;
    logic [ADDR_W-1:0]       r_n;
    logic [2:0]              r_lat_cnt;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic [31:0]             r_sample;
    logic [NUM_OUT-1:0]      r_exp;
    logic [NUM_OUT-1:0]      r_mask;
    logic [NUM_OUT-1:0]      r_out;
    logic                    r_ready;
    logic                    r_done;
    logic                    r_timeout;
    logic                    r_in_valid;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [ADDR_W-1:0]       r_corr_addr;
    logic                    r_mem_cs;
    logic                    r_corr_cs;
    logic                    r_clken;

    logic                    w_start_rise;
    logic [ADDR_W-1:0]       w_n_clamped;
    logic [ADDR_W-1:0]       w_idx_next;
    logic [NUM_OUT-1:0]      w_mismatch;
    logic [NUM_OUT-1:0][31:0] w_sums;
    logic [7:0][31:0]        w_sum8;
    logic                    w_unused_hi;

    assign w_start_rise = start_processing_chrom && !r_start_q;
    assign w_n_clamped  = (sequences_to_process > 32'(MAX_SAMPLES)) ? ADDR_W'(MAX_SAMPLES)
                                                                     : sequences_to_process[ADDR_W-1:0];
    assign w_idx_next   = r_idx + ADDR_W'(1);
    assign w_mismatch   = (r_out ^ r_exp) & r_mask;
    assign w_unused_hi  = ^{eval_out_data[31:NUM_OUT], correct_mem_s2_readdata[31:NUM_OUT]};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_idx       <= '0;
            r_n         <= '0;
            r_lat_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_sample    <= '0;
            r_exp       <= '0;
            r_mask      <= '0;
            r_out       <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_in_valid  <= 1'b0;
            r_mem_addr  <= '0;
            r_corr_addr <= '0;
            r_mem_cs    <= 1'b0;
            r_corr_cs   <= 1'b0;
            r_clken     <= 1'b0;
        end else begin
            r_start_q  <= start_processing_chrom;
            r_in_valid <= 1'b0;

            // Sample and expected word land MEM_RD_LATENCY cycles after RD_A.
            if (((r_state == S_RD_B) || (r_state == S_WAIT_MEM)) &&
                (r_lat_cnt == 3'(MEM_RD_LATENCY))) begin
                r_sample <= mem_s2_readdata;
                r_exp    <= correct_mem_s2_readdata[NUM_OUT-1:0];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_timeout <= 1'b0;
                        r_n       <= w_n_clamped;
                        r_idx     <= '0;
                        r_ready   <= 1'b0;
                        if (w_n_clamped == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_addr  <= '0;
                            r_corr_addr <= corr_addr('0, ADDR_W'(EXP_OFS));
                            r_mem_cs    <= 1'b1;
                            r_corr_cs   <= 1'b1;
                            r_clken     <= 1'b1;
                            r_state     <= S_RD_A;
                        end
                    end
                end
                S_RD_A: begin
                    r_mem_cs    <= 1'b0;
                    r_corr_addr <= corr_addr(r_idx, ADDR_W'(MASK_OFS));
                    r_lat_cnt   <= 3'd1;
                    r_state     <= S_RD_B;
                end
                S_RD_B: begin
                    r_corr_cs <= 1'b0;
                    r_lat_cnt <= r_lat_cnt + 3'd1;
                    r_state   <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    if (r_lat_cnt == 3'(MEM_RD_LATENCY + 1)) begin
                        r_mask     <= correct_mem_s2_readdata[NUM_OUT-1:0];
                        r_clken    <= 1'b0;
                        r_in_valid <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                S_ISSUE: begin
                    r_tmo_cnt <= TMO_W'(1);
                    r_state   <= S_WAIT_OUT;
                end
                S_WAIT_OUT: begin
                    if (eval_out_valid) begin
                        r_out   <= eval_out_data[NUM_OUT-1:0];
                        r_state <= S_ACCUM;
                    end else if (r_tmo_cnt >= TMO_W'(EVAL_TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (w_idx_next == r_n) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx       <= w_idx_next;
                        r_mem_addr  <= w_idx_next;
                        r_corr_addr <= corr_addr(w_idx_next, ADDR_W'(EXP_OFS));
                        r_mem_cs    <= 1'b1;
                        r_corr_cs   <= 1'b1;
                        r_clken     <= 1'b1;
                        r_state     <= S_RD_A;
                    end
                end
                S_DONE: begin
                    if (done_processing_feedback) begin
                        r_done  <= 1'b0;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!done_processing_feedback && !start_processing_chrom) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    error_accum #(
        .NUM_OUT (NUM_OUT)
    ) u_error_accum (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .clear    ((r_state == S_IDLE) && w_start_rise),
        .en       (r_state == S_ACCUM),
        .mismatch (w_mismatch),
        .sums     (w_sums)
    );

    for (genvar k = 0; k < 8; k++) begin : g_sum
        if (k < NUM_OUT) begin : g_live
            assign w_sum8[k] = w_sums[k];
        end else begin : g_pad
            assign w_sum8[k] = '0;
        end
    end

    assign error_sum_0 = w_sum8[0];
    assign error_sum_1 = w_sum8[1];
    assign error_sum_2 = w_sum8[2];
    assign error_sum_3 = w_sum8[3];
    assign error_sum_4 = w_sum8[4];
    assign error_sum_5 = w_sum8[5];
    assign error_sum_6 = w_sum8[6];
    assign error_sum_7 = w_sum8[7];

    assign ready_to_process          = r_ready;
    assign done_processing_chrom     = r_done;
    assign eval_timeout              = r_timeout;
    assign eval_in_valid             = r_in_valid;
    assign eval_in_data              = r_sample;
    assign mem_s2_address            = r_mem_addr;
    assign mem_s2_chipselect         = r_mem_cs;
    assign mem_s2_clken              = r_clken;
    assign mem_s2_write              = 1'b0;
    assign mem_s2_byteenable         = 4'hF;
    assign mem_s2_writedata          = '0;
    assign correct_mem_s2_address    = r_corr_addr;
    assign correct_mem_s2_chipselect = r_corr_cs;
    assign correct_mem_s2_clken      = r_clken;
    assign correct_mem_s2_write      = 1'b0;
    assign correct_mem_s2_byteenable = 4'hF;
    assign correct_mem_s2_writedata  = '0;

endmodule
`default_nettype wire

// File: tb/tb_fitness_eval_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fitness_eval_sequencer
//  Brief    : Directed self-checking bench with RAM and evaluator models.
//  Revision : 1.0
// ============================================================================
module tb_fitness_eval_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        fb;
    logic [31:0] nseq;

    logic        ready, done, tmo;
    logic [14:0] mem_addr, corr_addr;
    logic        mem_cs, mem_clken, mem_wr, corr_cs, corr_clken, corr_wr;
    logic [3:0]  mem_be, corr_be;
    logic [31:0] mem_wd, corr_wd;
    logic [31:0] mem_rdata = '0;
    logic [31:0] corr_rdata = '0;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic [31:0] sums [8];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_arr  [64];
    logic [31:0] corr_arr [128];
    logic [31:0] ev_lut   [16];
    logic [31:0] t2_exp   [4];
    logic [14:0] mem_log  [$];
    logic [14:0] corr_log [$];
    int          iv_count = 0;
    int          iv_base;
    int          cyc = 0;
    int          t0, t1;

    bit          ev_en  = 1'b1;
    int          ev_lat = 3;
    logic [3:0]  pcnt   = '0;
    logic [31:0] pdata  = '0;

    always #5 clk = ~clk;

    fitness_eval_sequencer #(
        .MEM_RD_LATENCY (1),
        .NUM_OUT        (8),
        .EVAL_TIMEOUT   (16)
    ) dut (
        .clk_clk                   (clk),
        .reset_reset_n             (rst_n),
        .start_processing_chrom    (start),
        .sequences_to_process      (nseq),
        .done_processing_feedback  (fb),
        .ready_to_process          (ready),
        .done_processing_chrom     (done),
        .eval_timeout              (tmo),
        .mem_s2_address            (mem_addr),
        .mem_s2_chipselect         (mem_cs),
        .mem_s2_clken              (mem_clken),
        .mem_s2_write              (mem_wr),
        .mem_s2_byteenable         (mem_be),
        .mem_s2_writedata          (mem_wd),
        .mem_s2_readdata           (mem_rdata),
        .correct_mem_s2_address    (corr_addr),
        .correct_mem_s2_chipselect (corr_cs),
        .correct_mem_s2_clken      (corr_clken),
        .correct_mem_s2_write      (corr_wr),
        .correct_mem_s2_byteenable (corr_be),
        .correct_mem_s2_writedata  (corr_wd),
        .correct_mem_s2_readdata   (corr_rdata),
        .eval_in_data              (in_data),
        .eval_in_valid             (in_valid),
        .eval_out_data             (out_data),
        .eval_out_valid            (out_valid),
        .error_sum_0               (sums[0]),
        .error_sum_1               (sums[1]),
        .error_sum_2               (sums[2]),
        .error_sum_3               (sums[3]),
        .error_sum_4               (sums[4]),
        .error_sum_5               (sums[5]),
        .error_sum_6               (sums[6]),
        .error_sum_7               (sums[7])
    );

    // Latency-1 on-chip RAMs, a fixed-latency evaluator and activity monitors.
    always @(posedge clk) begin
        if (mem_cs && mem_clken)   mem_rdata  <= mem_arr[mem_addr[5:0]];
        if (corr_cs && corr_clken) corr_rdata <= corr_arr[corr_addr[6:0]];
        if (in_valid) begin
            pcnt  <= 4'(ev_lat);
            pdata <= ev_lut[in_data[3:0]];
        end else if (pcnt != 4'd0) begin
            pcnt <= pcnt - 4'd1;
        end
        if (mem_cs)  mem_log.push_back(mem_addr);
        if (corr_cs) corr_log.push_back(corr_addr);
        if (in_valid) iv_count <= iv_count + 1;
        cyc <= cyc + 1;
    end

    assign out_valid = ev_en && (pcnt == 4'd1);
    assign out_data  = pdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run(input logic [31:0] n);
        mem_log.delete();
        corr_log.delete();
        iv_base = iv_count;
        nseq    = n;
        start   = 1'b1;
        tick(1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_done", 32'(done), 32'd1);
    endtask

    task automatic wait_iv(input int budget);
        int n = 0;
        while (in_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_in_valid", 32'(in_valid), 32'd1);
    endtask

    task automatic ack_run();
        fb = 1'b1;
        tick(2);
        chk("ack_done_low", 32'(done), 32'd0);
        fb    = 1'b0;
        start = 1'b0;
        tick(2);
        chk("ack_ready", 32'(ready), 32'd1);
    endtask

    task automatic load_single();
        mem_arr[0]  = 32'h5;
        corr_arr[0] = 32'hA5;
        corr_arr[1] = 32'hFF;
        ev_lut[5]   = 32'hA4;
    endtask

    initial begin
        for (int i = 0; i < 64; i++)  mem_arr[i]  = '0;
        for (int i = 0; i < 128; i++) corr_arr[i] = '0;
        for (int i = 0; i < 16; i++)  ev_lut[i]   = '0;
        rst_n = 1'b0;
        start = 1'b0;
        fb    = 1'b0;
        nseq  = '0;
        tick(3);

        // Reset state and tie-offs.
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        chk("rst_cs", {30'd0, mem_cs, corr_cs}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("tie_write", {30'd0, mem_wr, corr_wr}, 32'd0);
        chk("tie_be", {24'd0, mem_be, corr_be}, 32'hFF);
        chk("tie_wd", mem_wd | corr_wd, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single sample, one mismatching bit.
        load_single();
        start_run(1);
        chk("t1_ready_busy", 32'(ready), 32'd0);
        wait_iv(20);
        chk("t1_in_data", in_data, 32'h5);
        wait_done(40);
        for (int k = 0; k < 8; k++) chk($sformatf("t1_sum%0d", k), sums[k], (k == 0) ? 32'd1 : 32'd0);
        chk("t1_tmo", 32'(tmo), 32'd0);
        ack_run();

        // Four samples, low nibble masked in, every output bit inverted.
        t2_exp[0] = 32'h3C; t2_exp[1] = 32'hA5; t2_exp[2] = 32'h00; t2_exp[3] = 32'hFF;
        for (int i = 0; i < 4; i++) begin
            mem_arr[i]        = 32'(i);
            corr_arr[2*i]     = t2_exp[i];
            corr_arr[2*i + 1] = 32'h0F;
            ev_lut[i]         = ~t2_exp[i];
        end
        start_run(4);
        wait_done(100);
        for (int k = 0; k < 8; k++) chk($sformatf("t2_sum%0d", k), sums[k], (k < 4) ? 32'd4 : 32'd0);
        chk("t2_mem_log_size", 32'(mem_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_mem_addr%0d", i), (i < mem_log.size()) ? 32'(mem_log[i]) : 32'hDEAD, 32'(i));
        chk("t2_corr_log_size", 32'(corr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_corr_addr%0d", i), (i < corr_log.size()) ? 32'(corr_log[i]) : 32'hDEAD, 32'(i));
        ack_run();

        // N = 0: immediate done, sums cleared, no memory or evaluator traffic.
        start_run(0);
        if (done !== 1'b1) tick(1);
        chk("t3_done_fast", 32'(done), 32'd1);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_sum%0d", k), sums[k], 32'd0);
        chk("t3_no_cs", 32'(mem_log.size() + corr_log.size()), 32'd0);
        chk("t3_no_iv", 32'(iv_count - iv_base), 32'd0);
        ack_run();

        // Evaluator never answers: abort after 16 cycles.
        load_single();
        ev_en = 1'b0;
        start_run(1);
        wait_iv(20);
        t0 = cyc;
        begin
            int n = 0;
            while (done !== 1'b1 && n < 40) begin
                tick(1);
                n++;
            end
        end
        t1 = cyc;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_tmo", 32'(tmo), 32'd1);
        chk("t4_latency", 32'(t1 - t0), 32'd16);
        chk("t4_sum0", sums[0], 32'd0);
        ack_run();
        ev_en = 1'b1;

        // Reset during WAIT_OUT of the third sample, then a clean rerun.
        for (int i = 0; i < 5; i++) begin
            mem_arr[i]        = 32'(i);
            corr_arr[2*i]     = 32'h00;
            corr_arr[2*i + 1] = 32'hFF;
            ev_lut[i]         = 32'(i);
        end
        start_run(5);
        chk("t5_tmo_cleared", 32'(tmo), 32'd0);
        begin
            int n = 0;
            while ((iv_count - iv_base) < 3 && n < 100) begin
                tick(1);
                n++;
            end
        end
        chk("t5_third_issue", 32'(iv_count - iv_base), 32'd3);
        chk("t5_partial_sum0", sums[0], 32'd1);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(ready), 32'd1);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_ctrl", {28'd0, in_valid, mem_cs, corr_cs, mem_clken}, 32'd0);
        chk("t5_rst_addr", {2'd0, mem_addr, corr_addr}, 32'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("t5_rst_sum%0d", k), sums[k], 32'd0);
        tick(10);
        rst_n = 1'b1;
        tick(2);
        start_run(5);
        wait_done(200);
        chk("t5_rerun_first_addr", (mem_log.size() > 0) ? 32'(mem_log[0]) : 32'hDEAD, 32'd0);
        chk("t5_rerun_count", 32'(mem_log.size()), 32'd5);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t5_sum%0d", k), sums[k], (k < 2) ? 32'd2 : ((k == 2) ? 32'd1 : 32'd0));
        ack_run();

        // Start held high through ACK: no second run until it drops.
        load_single();
        start_run(1);
        wait_done(40);
        fb = 1'b1;
        tick(2);
        chk("t6_done_low", 32'(done), 32'd0);
        fb = 1'b0;
        tick(5);
        chk("t6_held_in_ack", 32'(ready), 32'd0);
        start = 1'b0;
        tick(2);
        chk("t6_ready", 32'(ready), 32'd1);
        tick(5);
        chk("t6_no_rerun_done", 32'(done), 32'd0);
        chk("t6_single_issue", 32'(iv_count - iv_base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fitness_eval_sequencer.md
Name: fitness_eval_sequencer

Overview:
- Sequences one chromosome-fitness evaluation between the HPS-side control PIOs and the evolved-circuit evaluator.
- On an HPS start request, it streams N input samples from the input-sequence RAM and expected/valid words from the correct-output RAM through the evaluator, using the on-chip RAM s2 ports.
- It accumulates per-output-bit mismatch counts into eight error sums, then signals done and completes the HPS done/feedback handshake.

Parameters:
- MEM_RD_LATENCY, 1, cycles from address/chipselect to s2 readdata valid; legal values 1..3.
- NUM_OUT, 8, number of evaluator output bits scored; one error sum per bit.
- EVAL_TIMEOUT, 1024, maximum cycles to wait for eval_out_valid before aborting.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- start_processing_chrom  in  1  HPS start request, level
- sequences_to_process  in  32  sample count N, captured at start
- done_processing_feedback  in  1  HPS acknowledge of done
- ready_to_process  out  1  idle and able to accept start
- done_processing_chrom  out  1  evaluation complete
- eval_timeout  out  1  last run aborted on evaluator timeout
- mem_s2_address  out  15  input-sequence RAM word address
- mem_s2_chipselect, mem_s2_clken  out  1 each  RAM enables
- mem_s2_write  out  1  tied 0
- mem_s2_byteenable  out  4  tied 4'hF
- mem_s2_writedata  out  32  tied 0
- mem_s2_readdata  in  32  input sample
- correct_mem_s2_address, correct_mem_s2_chipselect, correct_mem_s2_clken, correct_mem_s2_write, correct_mem_s2_byteenable, correct_mem_s2_writedata, correct_mem_s2_readdata: same widths, directions and tie-offs as the mem_s2_* ports.
- eval_in_data  out  32  sample to evaluator
- eval_in_valid  out  1  one-cycle sample strobe
- eval_out_data  in  32  evaluator result; bits [NUM_OUT-1:0] scored
- eval_out_valid  in  1  result strobe
- error_sum_0 .. error_sum_7  out  32 each  mismatch count per output bit

Behaviour:
- Reset values: ready_to_process=1; done, eval_timeout, eval_in_valid, all chipselect/clken=0; addresses=0; all error sums=0; FSM=IDLE.
- Memory map:
  - Sample i: mem word i.
  - Expected output: correct_mem word 2i.
  - Valid mask: correct_mem word 2i+1.
  - N is clamped to 16384; the internal index is 15 bits.
- FSM states: IDLE, RD_A, RD_B, WAIT_MEM, ISSUE, WAIT_OUT, ACCUM, DONE, ACK.
- IDLE:
  - ready=1. Start is taken on its rising edge only (registered previous value).
  - On start: clear sums and eval_timeout, latch N, set idx=0, ready=0.
  - If N==0, go directly to DONE; otherwise go to RD_A.
- RD_A: mem addr=idx and correct addr=2*idx, with chipselect/clken=1 on both RAMs, for one cycle.
- RD_B: correct addr=2*idx+1. Capture sample and expected MEM_RD_LATENCY cycles after RD_A, and mask MEM_RD_LATENCY cycles after RD_B. WAIT_MEM pads to the later capture.
- ISSUE: eval_in_valid=1 for exactly one cycle with eval_in_data=sample. Exactly one sample is in flight.
- WAIT_OUT:
  - On eval_out_valid, register the result and go to ACCUM.
  - A timeout counter runs from ISSUE. When it reaches EVAL_TIMEOUT, set eval_timeout=1 and go to DONE; partial sums are kept.
  - eval_out_valid asserted outside WAIT_OUT is ignored.
- ACCUM:
  - For each bit k < NUM_OUT: error_sum_k += ((out ^ expected) & mask)[k]. Sums saturate at 32'hFFFF_FFFF.
  - idx++. If idx==N go to DONE, else go to RD_A.
- DONE: done=1 until done_processing_feedback=1, then go to ACK.
- ACK: done=0. Wait until feedback=0 and start=0, then go to IDLE with ready=1. Error sums hold their values until the next start.
- Start deasserted mid-run is ignored; the run completes.
- Feedback asserted outside DONE is ignored.
- Asynchronous reset mid-run aborts immediately to the reset values.
- Per-sample latency is 5 + MEM_RD_LATENCY-1 + evaluator latency cycles.

Decomposition:
- Package fitness_eval_pkg holds:
  - the state enum;
  - constants ADDR_W=15 and MAX_SAMPLES=16384;
  - the memory-map offsets EXP_OFS=0, MASK_OFS=1 and STRIDE=2.
- One sub-module, error_accum: NUM_OUT saturating 32-bit counters with clear, enable and a mismatch-vector input.

Test Plan:
- N=1, mem[0]=0x5, correct[0]=0xA5, correct[1]=0xFF, evaluator returns 0xA4 after 3 cycles -> error_sum_0=1, all other sums 0, done=1; feedback pulse -> ready=1.
- N=4, mask=0x0F for all samples, all outputs inverted from expected -> error_sum_0..3=4, error_sum_4..7=0; addresses sequence mem 0,1,2,3 and correct 0,1,…,7.
- N=0 -> done asserted within 2 cycles of start; sums 0; no chipselect and no eval_in_valid.
- Evaluator never responds, EVAL_TIMEOUT=16 -> eval_timeout=1 and done=1 exactly 16 cycles after eval_in_valid.
- reset_reset_n low during WAIT_OUT of sample 2 of 5 -> all outputs at reset values; a new start runs from idx 0.
- Start held high through ACK, feedback dropped -> stays in ACK (ready=0) until start=0; no second run.
